// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, PC register index and writeback entry type
package regfile_pkg;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam logic [3:0] PC_IDX = 4'hF;
   typedef struct packed {
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
   } wb_entry_t;
endpackage

// File: rtl/regfile_write_sequencer_wb_fifo.sv
// wb_fifo: 2-in/1-out writeback queue exposing every entry for hazard compare
//   clk, reset_n    : clock, async active-low reset
//   clr             : synchronous discard of all entries
//   wr0_*, wr1_*    : two write slots, slot0 lands before slot1
//   rd_en           : pop head
//   head_wa/head_wd : current head entry
//   count           : valid entries
//   ent_wa/ent_vld  : raw storage addresses and per-entry valid bits
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int AW = 4,
   parameter int DW = 32,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clr,
   input  logic                     wr0_en,
   input  logic [AW-1:0]            wr0_wa,
   input  logic [DW-1:0]            wr0_wd,
   input  logic                     wr1_en,
   input  logic [AW-1:0]            wr1_wa,
   input  logic [DW-1:0]            wr1_wd,
   input  logic                     rd_en,
   output logic [AW-1:0]            head_wa,
   output logic [DW-1:0]            head_wd,
   output logic [PW:0]              count,
   output logic [DEPTH-1:0][AW-1:0] ent_wa,
   output logic [DEPTH-1:0]         ent_vld
);
   logic [PW-1:0] head, tail, tail1;
   logic [DEPTH-1:0][AW-1:0] wa_q;
   logic [DEPTH-1:0][DW-1:0] wd_q;
   logic [1:0] n_wr;
   // slot1 packs directly behind slot0, or takes the tail itself when slot0 was filtered out
   assign tail1 = tail + PW'(wr0_en);
   assign n_wr = {1'b0, wr0_en} + {1'b0, wr1_en};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else if (clr) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         head <= head + PW'(rd_en);
         tail <= tail + PW'(n_wr);
         count <= count + (PW+1)'(n_wr) - (PW+1)'(rd_en);
      end
   always_ff @(posedge clk) begin
      if (wr0_en) begin
         wa_q[tail] <= wr0_wa;
         wd_q[tail] <= wr0_wd;
      end
      if (wr1_en) begin
         wa_q[tail1] <= wr1_wa;
         wd_q[tail1] <= wr1_wd;
      end
   end
   // an entry is live when its distance from head is below count
   always_comb begin
      ent_vld = '0;
      for (int i = 0; i < DEPTH; i++)
         ent_vld[i] = {1'b0, PW'(i) - head} < count;
   end
   assign head_wa = wa_q[head];
   assign head_wd = wd_q[head];
   assign ent_wa = wa_q;
endmodule

// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer: serialises single/dual writeback results onto one register-file write port
//   clk, reset_n             : clock, async active-low reset
//   in_valid/in_ready        : request handshake; in_ready needs two free entries
//   in_dual, in_wa0/1, in_wd0/1 : one or two writes, slot0 issued first; PC-targeted slots dropped
//   flush                    : discard queued entries, in-flight write still completes
//   WA, WD, RegWrite         : register-file write port
//   chk_ra1..3, hazard1..3   : pending-write hazard on read addresses
//   busy, count              : activity and queue occupancy
module regfile_write_sequencer #(
   parameter int DEPTH = 4,
   parameter int AW = regfile_pkg::AW,
   parameter int DW = regfile_pkg::DW,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_dual,
   input  logic [AW-1:0] in_wa0,
   input  logic [DW-1:0] in_wd0,
   input  logic [AW-1:0] in_wa1,
   input  logic [DW-1:0] in_wd1,
   input  logic          flush,
   output logic [AW-1:0] WA,
   output logic [DW-1:0] WD,
   output logic          RegWrite,
   input  logic [AW-1:0] chk_ra1,
   input  logic [AW-1:0] chk_ra2,
   input  logic [AW-1:0] chk_ra3,
   output logic          hazard1,
   output logic          hazard2,
   output logic          hazard3,
   output logic          busy,
   output logic [CW-1:0] count
);
   import regfile_pkg::*;
   localparam logic [AW-1:0] PC = AW'(PC_IDX);
   logic acc, wr0_en, wr1_en, rd_en;
   logic [AW-1:0] head_wa;
   logic [DW-1:0] head_wd;
   logic [DEPTH-1:0][AW-1:0] ent_wa;
   logic [DEPTH-1:0] ent_vld;
   logic [2:0][AW-1:0] ra;
   logic [2:0] haz;
   // readiness depends only on occupancy so in_dual never feeds in_ready
   assign in_ready = count <= CW'(DEPTH - 2);
   assign acc = in_valid && in_ready && !flush;
   assign wr0_en = acc && in_wa0 != PC;
   assign wr1_en = acc && in_dual && in_wa1 != PC;
   assign rd_en = count != '0 && !flush;
   wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (flush),
      .wr0_en  (wr0_en),
      .wr0_wa  (in_wa0),
      .wr0_wd  (in_wd0),
      .wr1_en  (wr1_en),
      .wr1_wa  (in_wa1),
      .wr1_wd  (in_wd1),
      .rd_en   (rd_en),
      .head_wa (head_wa),
      .head_wd (head_wd),
      .count   (count),
      .ent_wa  (ent_wa),
      .ent_vld (ent_vld)
   );
   // WA/WD hold their last value while idle; only the strobe drops
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         WA <= '0;
         WD <= '0;
         RegWrite <= 1'b0;
      end else begin
         RegWrite <= rd_en;
         if (rd_en) begin
            WA <= head_wa;
            WD <= head_wd;
         end
      end
   assign ra = {chk_ra3, chk_ra2, chk_ra1};
   always_comb begin
      haz = '0;
      for (int j = 0; j < 3; j++) begin
         haz[j] = RegWrite && WA == ra[j];
         for (int i = 0; i < DEPTH; i++)
            haz[j] = haz[j] || (ent_vld[i] && ent_wa[i] == ra[j]);
         haz[j] = haz[j] && ra[j] != PC;
      end
   end
   assign hazard1 = haz[0];
   assign hazard2 = haz[1];
   assign hazard3 = haz[2];
   assign busy = count != '0 || RegWrite;
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// tb_regfile_write_sequencer: directed self-checking bench for regfile_write_sequencer
module tb_regfile_write_sequencer;
   import regfile_pkg::*;
   localparam int DEPTH = 4;
   logic clk = 0, reset_n = 0, in_valid = 0, in_dual = 0, flush = 0;
   logic [3:0] in_wa0 = 0, in_wa1 = 0, chk_ra1 = 0, chk_ra2 = 0, chk_ra3 = 0;
   logic [31:0] in_wd0 = 0, in_wd1 = 0;
   logic in_ready, RegWrite, hazard1, hazard2, hazard3, busy;
   logic [3:0] WA;
   logic [31:0] WD;
   logic [2:0] count;
   int n_cmp = 0, n_err = 0;
   wb_entry_t mq[$];
   logic mrw = 0;
   logic [3:0] mwa = 0;
   logic [31:0] mwd = 0;

   regfile_write_sequencer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_dual(in_dual), .in_wa0(in_wa0), .in_wd0(in_wd0), .in_wa1(in_wa1), .in_wd1(in_wd1),
      .flush(flush), .WA(WA), .WD(WD), .RegWrite(RegWrite),
      .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_ra3(chk_ra3),
      .hazard1(hazard1), .hazard2(hazard2), .hazard3(hazard3), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   // reference queue: pop head into the output register, then append accepted non-PC slots
   task automatic model_edge(input logic acc);
      wb_entry_t e;
      if (mq.size() > 0) begin
         e = mq.pop_front();
         mrw = 1;
         mwa = e.wa;
         mwd = e.wd;
      end else mrw = 0;
      if (acc) begin
         if (in_wa0 != 4'hF) mq.push_back('{wa: in_wa0, wd: in_wd0});
         if (in_dual && in_wa1 != 4'hF) mq.push_back('{wa: in_wa1, wd: in_wd1});
      end
   endtask

   function automatic logic model_haz(input logic [3:0] a);
      logic h = mrw && mwa == a;
      foreach (mq[k]) if (mq[k].wa == a) h = 1;
      return h && a != 4'hF;
   endfunction

   task automatic test_reset;
      reset_n = 0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1;
      @(negedge clk);
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
      n_cmp++; if (WA !== 4'h0) begin n_err++; $display("FAIL reset_wa: got %h want 0", WA); end
      n_cmp++; if (WD !== 32'h0) begin n_err++; $display("FAIL reset_wd: got %h want 0", WD); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if ({hazard1, hazard2, hazard3} !== 3'b000) begin n_err++; $display("FAIL reset_hazards: got %b want 000", {hazard1, hazard2, hazard3}); end
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      in_valid = 1; in_dual = 0; in_wa0 = 3; in_wd0 = 32'hDEADBEEF; chk_ra1 = 3;
      @(posedge clk); #1 in_valid = 0;
      n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count_queued: got %0d want 1", count); end
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_regwrite_early: got %b want 0", RegWrite); end
      n_cmp++; if (hazard1 !== 1'b1) begin n_err++; $display("FAIL single_hazard_queued: got %b want 1", hazard1); end
      @(posedge clk); #1;
      n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL single_regwrite: got %b want 1", RegWrite); end
      n_cmp++; if (WA !== 4'd3) begin n_err++; $display("FAIL single_wa: got %h want 3", WA); end
      n_cmp++; if (WD !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wd: got %h want deadbeef", WD); end
      n_cmp++; if (hazard1 !== 1'b1) begin n_err++; $display("FAIL single_hazard_out: got %b want 1", hazard1); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count_drained: got %0d want 0", count); end
      @(posedge clk); #1;
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_regwrite_off: got %b want 0", RegWrite); end
      n_cmp++; if (WA !== 4'd3) begin n_err++; $display("FAIL single_wa_hold: got %h want 3", WA); end
      n_cmp++; if (hazard1 !== 1'b0) begin n_err++; $display("FAIL single_hazard_clear: got %b want 0", hazard1); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %b want 0", busy); end
      chk_ra1 = 0; mq.delete(); mrw = 0;
   endtask

   task automatic test_back_to_back;
      logic dl [5] = '{1, 1, 0, 0, 0};
      logic [3:0] a0 [5] = '{2, 6, 9, 10, 11};
      logic [31:0] d0 [5] = '{32'h11, 32'h33, 32'h55, 32'h66, 32'h77};
      logic [3:0] a1 [5] = '{5, 8, 0, 0, 0};
      logic [31:0] d1 [5] = '{32'h22, 32'h44, 0, 0, 0};
      logic [3:0] ewa [7] = '{2, 5, 6, 8, 9, 10, 11};
      logic [31:0] ewd [7] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77};
      wb_entry_t got[$];
      int i = 0;
      logic saw_drop = 0, acc;
      chk_ra2 = 6;
      for (int c = 0; c < 16; c++) begin
         in_valid = i < 5;
         if (i < 5) begin in_dual = dl[i]; in_wa0 = a0[i]; in_wd0 = d0[i]; in_wa1 = a1[i]; in_wd1 = d1[i]; end
         @(negedge clk);
         n_cmp++; if (in_ready !== (mq.size() <= DEPTH - 2)) begin n_err++; $display("FAIL b2b_in_ready c%0d: got %b want %b", c, in_ready, mq.size() <= DEPTH - 2); end
         n_cmp++; if (count !== 3'(mq.size())) begin n_err++; $display("FAIL b2b_count c%0d: got %0d want %0d", c, count, mq.size()); end
         n_cmp++; if (hazard2 !== model_haz(6)) begin n_err++; $display("FAIL b2b_hazard2 c%0d: got %b want %b", c, hazard2, model_haz(6)); end
         n_cmp++; if (RegWrite !== mrw) begin n_err++; $display("FAIL b2b_regwrite c%0d: got %b want %b", c, RegWrite, mrw); end
         if (RegWrite) got.push_back('{wa: WA, wd: WD});
         acc = in_valid && mq.size() <= DEPTH - 2;
         if (in_valid && !acc) saw_drop = 1;
         @(posedge clk);
         model_edge(acc);
         if (acc) i++;
         #1;
      end
      in_valid = 0; chk_ra2 = 0;
      n_cmp++; if (saw_drop !== 1'b1) begin n_err++; $display("FAIL b2b_ready_drop: got %b want 1", saw_drop); end
      n_cmp++; if (i != 5) begin n_err++; $display("FAIL b2b_all_accepted: got %0d want 5", i); end
      n_cmp++; if (got.size() != 7) begin n_err++; $display("FAIL b2b_write_count: got %0d want 7", got.size()); end
      for (int k = 0; k < 7 && k < got.size(); k++) begin
         n_cmp++; if (got[k].wa !== ewa[k] || got[k].wd !== ewd[k]) begin n_err++; $display("FAIL b2b_order[%0d]: got %h/%h want %h/%h", k, got[k].wa, got[k].wd, ewa[k], ewd[k]); end
      end
   endtask

   task automatic test_pc_filter;
      int nw = 0;
      logic [3:0] lw = 0;
      logic [31:0] ld = 0;
      logic acc;
      chk_ra1 = 15; chk_ra3 = 7;
      for (int c = 0; c < 5; c++) begin
         in_valid = c == 0; in_dual = 1; in_wa0 = 15; in_wd0 = 32'hAA; in_wa1 = 7; in_wd1 = 32'hBB;
         @(negedge clk);
         n_cmp++; if (hazard1 !== 1'b0) begin n_err++; $display("FAIL pc_hazard1 c%0d: got %b want 0", c, hazard1); end
         n_cmp++; if (hazard3 !== model_haz(7)) begin n_err++; $display("FAIL pc_hazard3 c%0d: got %b want %b", c, hazard3, model_haz(7)); end
         n_cmp++; if (count !== 3'(mq.size())) begin n_err++; $display("FAIL pc_count c%0d: got %0d want %0d", c, count, mq.size()); end
         if (RegWrite) begin nw++; lw = WA; ld = WD; end
         acc = in_valid && mq.size() <= DEPTH - 2;
         @(posedge clk);
         model_edge(acc);
         #1;
      end
      in_valid = 0; in_dual = 0; chk_ra1 = 0; chk_ra3 = 0;
      n_cmp++; if (nw != 1) begin n_err++; $display("FAIL pc_write_count: got %0d want 1", nw); end
      n_cmp++; if (lw !== 4'd7 || ld !== 32'hBB) begin n_err++; $display("FAIL pc_write: got %h/%h want 7/bb", lw, ld); end
   endtask

   task automatic test_flush;
      in_valid = 1; in_dual = 1; in_wa0 = 1; in_wd0 = 32'hA1; in_wa1 = 2; in_wd1 = 32'hA2;
      @(posedge clk); #1 in_wa0 = 3; in_wd0 = 32'hA3; in_wa1 = 4; in_wd1 = 32'hA4;
      @(posedge clk); #1 flush = 1; in_dual = 0; in_wa0 = 9; in_wd0 = 32'h99;
      @(negedge clk);
      n_cmp++; if (RegWrite !== 1'b1 || WA !== 4'd1) begin n_err++; $display("FAIL flush_inflight: got %b/%h want 1/1", RegWrite, WA); end
      n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_count_before: got %0d want 3", count); end
      @(posedge clk); #1 flush = 0; in_valid = 0;
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count_after: got %0d want 0", count); end
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL flush_regwrite_after: got %b want 0", RegWrite); end
      n_cmp++; if (WA !== 4'd1 || WD !== 32'hA1) begin n_err++; $display("FAIL flush_out_hold: got %h/%h want 1/a1", WA, WD); end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL flush_no_issue c%0d: got %b want 0", c, RegWrite); end
      end
      in_valid = 1; flush = 1; in_wa0 = 5; in_wd0 = 32'h55;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_accept_ready: got %b want 1", in_ready); end
      @(posedge clk); #1 in_valid = 0; flush = 0;
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_discard_count: got %0d want 0", count); end
      @(posedge clk); #1;
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL flush_discard_write: got %b want 0", RegWrite); end
   endtask

   task automatic test_reset_mid;
      in_valid = 1; in_dual = 1; in_wa0 = 1; in_wd0 = 32'hB1; in_wa1 = 2; in_wd1 = 32'hB2;
      @(posedge clk); #1 in_wa0 = 3; in_wd0 = 32'hB3; in_wa1 = 4; in_wd1 = 32'hB4;
      @(posedge clk); #1 in_valid = 0; in_dual = 0;
      n_cmp++; if (RegWrite !== 1'b1 || count !== 3'd3) begin n_err++; $display("FAIL rstmid_before: got %b/%0d want 1/3", RegWrite, count); end
      #2 reset_n = 0;
      #1;
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rstmid_regwrite: got %b want 0", RegWrite); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", count); end
      n_cmp++; if (WA !== 4'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_wa_busy: got %h/%b want 0/0", WA, busy); end
      #2 reset_n = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++; if (RegWrite !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL rstmid_after c%0d: got %b/%0d want 0/0", c, RegWrite, count); end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_pc_filter;
      test_flush;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
